// File: rtl/instrman_ot_pkg.sv
// rtl/instrman_ot_pkg.sv - shared constants and sizing helpers for the fetch manager
package instrman_ot_pkg;

  localparam int INSTR_BYTES = 4;

  function automatic int line_bytes(input int bus_len);
    return INSTR_BYTES * bus_len;
  endfunction

  // A one-entry FIFO still needs a (constant) one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instrman_ot_fetch_tag_fifo.sv
// rtl/instrman_ot_fetch_tag_fifo.sv - circular FIFO of {fetch addr, stale} tags for in-flight requests
module instrman_ot_fetch_tag_fifo
  import instrman_ot_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [AW-1:0]                push_addr,
  input  logic                         pop,
  input  logic                         mark_stale,
  output logic [AW-1:0]                head_addr,
  output logic                         head_stale,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic          stale_q [DEPTH];
  logic          stale_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    addr_d  = addr_q;
    stale_d = stale_q;
    // Stale marking covers entries present at cycle start; the push below overrides its slot.
    if (mark_stale) begin
      for (int i = 0; i < DEPTH; i++) begin
        stale_d[i] = 1'b1;
      end
    end
    if (push) begin
      addr_d[wr_ptr_q]  = push_addr;
      stale_d[wr_ptr_q] = 1'b0;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    stale_q <= stale_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr  = addr_q[rd_ptr_q];
  assign head_stale = stale_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/instrman_ot.sv
// rtl/instrman_ot.sv - instruction fetch manager with up to OT_DEPTH outstanding in-order requests
module instrman_ot
  import instrman_ot_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter int             BUS_LEN  = 2,
  parameter int             OT_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [XLEN-1:0]               imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_resp,
  input  logic [32*BUS_LEN-1:0]         imem_rdata,
  input  logic                          imem_err,
  input  logic                          jump_vld,
  input  logic [XLEN-1:0]               jump_pc,
  input  logic                          branch_vld,
  input  logic [XLEN-1:0]               branch_pc,
  input  logic                          buffer_free,
  output logic                          imem_vld,
  output logic [32*BUS_LEN-1:0]         imem_instr,
  output logic                          imem_status,
  output logic [XLEN-1:0]               imem_pc,
  output logic [$clog2(OT_DEPTH+1)-1:0] ot_cnt,
  output logic                          resp_spurious
);

  localparam int              LB       = line_bytes(BUS_LEN);
  localparam int              CW       = cnt_width(OT_DEPTH);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(LB - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_spurious_q, resp_spurious_d;
  logic            reload_vld;
  logic [XLEN-1:0] reload_sel;
  logic [XLEN-1:0] reload_pc;
  logic [XLEN-1:0] fetch_addr;
  logic            credit;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            head_stale;
  logic [XLEN-1:0] head_addr;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    reload_vld = jump_vld | branch_vld;
    reload_sel = jump_vld ? jump_pc : branch_pc;
    reload_pc  = {reload_sel[XLEN-1:1], 1'b0};
    fetch_addr = reload_vld ? reload_pc : pc_q;
    imem_addr  = fetch_addr & PC_ALIGN;

    // A response retires its slot this cycle, so it counts as credit immediately.
    credit   = ~fifo_full | imem_resp;
    imem_req = (buffer_free | reload_vld) & credit;
    accept   = imem_req & imem_gnt;
    pop      = imem_resp & ~fifo_empty;
    imem_vld = pop & ~head_stale & ~reload_vld;

    pc_d = pc_q;
    if (accept) begin
      pc_d = imem_addr + XLEN'(LB);
    end else if (reload_vld) begin
      pc_d = reload_pc;
    end

    resp_spurious_d = resp_spurious_q | (imem_resp & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      resp_spurious_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      resp_spurious_q <= resp_spurious_d;
    end
  end

  instrman_ot_fetch_tag_fifo #(
    .AW    (XLEN),
    .DEPTH (OT_DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_addr  (fetch_addr),
    .pop        (pop),
    .mark_stale (reload_vld),
    .head_addr  (head_addr),
    .head_stale (head_stale),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign imem_instr    = imem_rdata;
  assign imem_status   = imem_err;
  assign imem_pc       = head_addr;
  assign ot_cnt        = fifo_count;
  assign resp_spurious = resp_spurious_q;

endmodule

// File: tb/tb_instrman_ot.sv
// tb/tb_instrman_ot.sv - self-checking bench for instrman_ot against a queue-based reference model
module tb_instrman_ot;

  localparam int          XLEN     = 32;
  localparam int          BUS_LEN  = 2;
  localparam int          BUS_WID  = 32 * BUS_LEN;
  localparam int          OT_DEPTH = 4;
  localparam int          LB       = 4 * BUS_LEN;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt = 1'b0;
  logic               imem_resp = 1'b0;
  logic [BUS_WID-1:0] imem_rdata = '0;
  logic               imem_err = 1'b0;
  logic               jump_vld = 1'b0;
  logic [XLEN-1:0]    jump_pc = '0;
  logic               branch_vld = 1'b0;
  logic [XLEN-1:0]    branch_pc = '0;
  logic               buffer_free = 1'b0;
  logic               imem_vld;
  logic [BUS_WID-1:0] imem_instr;
  logic               imem_status;
  logic [XLEN-1:0]    imem_pc;
  logic [2:0]         ot_cnt;
  logic               resp_spurious;

  always #5 clk = ~clk;

  instrman_ot #(
    .XLEN     (XLEN),
    .BUS_LEN  (BUS_LEN),
    .OT_DEPTH (OT_DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_resp     (imem_resp),
    .imem_rdata    (imem_rdata),
    .imem_err      (imem_err),
    .jump_vld      (jump_vld),
    .jump_pc       (jump_pc),
    .branch_vld    (branch_vld),
    .branch_pc     (branch_pc),
    .buffer_free   (buffer_free),
    .imem_vld      (imem_vld),
    .imem_instr    (imem_instr),
    .imem_status   (imem_status),
    .imem_pc       (imem_pc),
    .ot_cnt        (ot_cnt),
    .resp_spurious (resp_spurious)
  );

  // Reference model: in-flight fetches as a queue of tags, plus the next sequential PC.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } tag_t;

  tag_t        tq[$];
  logic [31:0] m_pc;
  bit          m_spur;
  bit          m_acc;

  int n_chk  = 0;
  int n_fail = 0;

  logic        s_req, s_vld, s_spur;
  logic [31:0] s_addr, s_pc;
  logic [2:0]  s_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    buffer_free = 0; imem_gnt = 0; imem_resp = 0; imem_err = 0;
    jump_vld = 0; branch_vld = 0; jump_pc = '0; branch_pc = '0; imem_rdata = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tq.delete();
    m_pc   = RESET_PC;
    m_spur = 0;
    @(negedge clk);
    chk("rst_ot_cnt", ot_cnt, 0);
    chk("rst_spurious", resp_spurious, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_vld", imem_vld, 0);
    chk("rst_addr", imem_addr, RESET_PC & ~32'(LB - 1));
    @(posedge clk); #1;
  endtask

  // Inputs are already applied; check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit          reload, credit, req, pop, vld;
    logic [31:0] rpc, fa, al;
    tag_t        hd;
    @(negedge clk);
    reload = jump_vld || branch_vld;
    rpc    = (jump_vld ? jump_pc : branch_pc) & ~32'h1;
    fa     = reload ? rpc : m_pc;
    al     = fa & ~32'(LB - 1);
    credit = (tq.size() != OT_DEPTH) || imem_resp;
    req    = (buffer_free || reload) && credit;
    m_acc  = req && imem_gnt;
    pop    = imem_resp && (tq.size() != 0);
    vld    = 0;
    hd     = '{addr: 32'h0, stale: 1'b0};
    if (pop) begin
      hd  = tq[0];
      vld = !hd.stale && !reload;
    end

    s_req = imem_req; s_addr = imem_addr; s_vld = imem_vld;
    s_pc = imem_pc; s_cnt = ot_cnt; s_spur = resp_spurious;

    chk("req", imem_req, req);
    chk("addr", imem_addr, al);
    chk("vld", imem_vld, vld);
    chk("ot_cnt", ot_cnt, tq.size());
    chk("spurious", resp_spurious, m_spur);
    chk("instr", imem_instr, imem_rdata);
    if (vld) begin
      chk("pc", imem_pc, hd.addr);
      chk("status", imem_status, imem_err);
    end

    if (pop) hd = tq.pop_front();
    if (imem_resp && !pop) m_spur = 1;
    if (reload) foreach (tq[i]) tq[i].stale = 1;
    if (m_acc) tq.push_back('{addr: fa, stale: 1'b0});
    m_pc = m_acc ? al + 32'(LB) : (reload ? rpc : m_pc);
    @(posedge clk); #1;
  endtask

  initial begin
    bit h1, h2;
    int acc_cnt;

    // Streaming with responses two cycles after each accept.
    do_reset();
    buffer_free = 1; imem_gnt = 1;
    h1 = 0; h2 = 0;
    for (int i = 0; i < 8; i++) begin
      imem_resp  = h2;
      imem_rdata = {$urandom, $urandom};
      cycle();
      if (i < 4) chk("stream_addr", s_addr, 32'(i * 8));
      if (i >= 2) chk("stream_cnt", s_cnt, 2);
      h2 = h1; h1 = m_acc;
    end

    // Credit limit.
    do_reset();
    buffer_free = 1; imem_gnt = 1; imem_resp = 0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_req && imem_gnt) acc_cnt++;
    end
    chk("credit_accepts", acc_cnt, 4);
    imem_resp = 1;
    cycle();
    chk("credit_full_cnt", s_cnt, 4);
    chk("credit_resp_req", s_req, 1);
    imem_resp = 0;
    cycle();
    chk("credit_blocked_req", s_req, 0);

    // Branch flush with three lines outstanding.
    do_reset();
    buffer_free = 1; imem_gnt = 1;
    for (int i = 0; i < 3; i++) cycle();
    branch_vld = 1; branch_pc = 32'h103;
    cycle();
    chk("flush_addr", s_addr, 32'h100);
    branch_vld = 0; buffer_free = 0; imem_resp = 1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = {$urandom, $urandom};
      cycle();
      chk("flush_vld", s_vld, (i == 3) ? 1 : 0);
      if (i == 3) chk("flush_pc", s_pc, 32'h102);
    end
    imem_resp = 0; buffer_free = 1;
    cycle();
    chk("flush_next_addr", s_addr, 32'h108);

    // Jump, branch and response together.
    do_reset();
    buffer_free = 1; imem_gnt = 1;
    cycle();
    buffer_free = 0; jump_vld = 1; jump_pc = 32'h40;
    branch_vld = 1; branch_pc = 32'h200; imem_resp = 1;
    cycle();
    chk("simul_addr", s_addr, 32'h40);
    chk("simul_vld", s_vld, 0);
    zero_inputs();
    imem_gnt = 1;
    cycle();

    // Spurious response.
    do_reset();
    imem_resp = 1;
    cycle();
    chk("spur_cnt", s_cnt, 0);
    chk("spur_vld", s_vld, 0);
    imem_resp = 0;
    cycle();
    chk("spur_set", s_spur, 1);
    cycle();
    chk("spur_sticky", s_spur, 1);
    do_reset();

    // Grant stall, then a branch during the stall.
    buffer_free = 1; imem_gnt = 1;
    cycle();
    imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr", s_addr, 32'h8);
    end
    branch_vld = 1; branch_pc = 32'h20;
    cycle();
    chk("stall_branch_addr", s_addr, 32'h20);
    branch_vld = 0;
    cycle();
    chk("stall_after_branch", s_addr, 32'h20);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      buffer_free = ($urandom % 4) != 0;
      imem_gnt    = ($urandom % 4) != 0;
      imem_resp   = (tq.size() != 0) ? (($urandom % 2) == 1) : (($urandom % 60) == 0);
      imem_err    = ($urandom % 8) == 0;
      jump_vld    = ($urandom % 16) == 0;
      branch_vld  = ($urandom % 10) == 0;
      jump_pc     = $urandom;
      branch_pc   = $urandom;
      imem_rdata  = {$urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
